// File: rtl/button_rgb_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : button_rgb_pkg
//  Description : Shared types and constants for the button-driven RGB reader:
//                press-classifier FSM states and the 7-entry colour table.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_rgb_pkg;

  // Press classifier states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_t;

  // Colour sequence, active-high {R,G,B}; entry 0 is leftmost
  localparam logic [0:6][2:0] COLOUR_TABLE = {
    3'b100,   // 0 R
    3'b010,   // 1 G
    3'b001,   // 2 B
    3'b110,   // 3 R+G
    3'b011,   // 4 G+B
    3'b101,   // 5 R+B
    3'b111    // 6 R+G+B
  };

  localparam logic [2:0] COLOUR_LAST  = 3'd6;
  localparam logic [2:0] COLOUR_RESET = 3'd1;

  // Table lookup; the unused index 7 maps to dark rather than out of range
  function automatic logic [2:0] colour_rgb(input logic [2:0] idx);
    colour_rgb = (idx <= COLOUR_LAST) ? COLOUR_TABLE[idx] : 3'b000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_rgb_reader_debouncer.sv
`default_nettype none
// ============================================================================
//  Module      : button_debouncer
//  Description : Two-flop synchroniser for the raw active-low button, a
//                consecutive-sample debouncer and press/release edge detect.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic db,
  output logic press_evt,
  output logic release_evt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic             sync1;
  logic             btn_s;
  logic [CNT_W-1:0] cnt;
  logic             db_q;

  // Synchroniser; both stages idle at the released level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= btn_n;
      btn_s <= sync1;
    end
  end

  // Accept a level change only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (!btn_s == db) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      db  <= ~db;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Previous debounced level for edge detection
  always_ff @(posedge clk) begin
    if (rst) db_q <= 1'b0;
    else     db_q <= db;
  end

  assign press_evt   =  db & ~db_q;
  assign release_evt = ~db &  db_q;

endmodule
`default_nettype wire

// File: rtl/button_rgb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : button_rgb_reader
//  Description : Debounced user button classified into short/long presses.
//                Short presses step a 7-colour sequence, long presses toggle
//                the LEDs. LED outputs are registered and active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_rgb_reader
  import button_rgb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_pressed,
  output logic short_pulse,
  output logic long_pulse,
  output logic led_red,
  output logic led_green,
  output logic led_blue
);

  localparam int HOLD_W = $clog2(LONG_CYCLES);

  logic              db;
  logic              press_evt;
  logic              release_evt;
  btn_state_t        state;
  btn_state_t        state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              short_evt;
  logic              long_evt;
  logic [2:0]        colour_idx;
  logic              leds_on;
  logic [2:0]        lit_rgb;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .db          (db),
    .press_evt   (press_evt),
    .release_evt (release_evt)
  );

  assign btn_pressed = db;
  assign hold_done   = (hold_cnt == HOLD_W'(LONG_CYCLES - 1));

  // Classifier state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Hold-length counter: cleared on press, counts while held, parks at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == ST_IDLE && press_evt) begin
      hold_cnt <= '0;
    end else if (state == ST_HELD && !hold_done) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Next-state logic; a release beats the long threshold in the same cycle
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (press_evt) state_nxt = ST_HELD;
      ST_HELD: begin
        if (release_evt)    state_nxt = ST_IDLE;
        else if (hold_done) state_nxt = ST_LONG;
      end
      ST_LONG: if (release_evt) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Classification events, decoded from the HELD state only
  always_comb begin
    short_evt = 1'b0;
    long_evt  = 1'b0;
    if (state == ST_HELD) begin
      if (release_evt)    short_evt = 1'b1;
      else if (hold_done) long_evt  = 1'b1;
    end
  end

  // Registered one-cycle pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      short_pulse <= 1'b0;
      long_pulse  <= 1'b0;
    end else begin
      short_pulse <= short_evt;
      long_pulse  <= long_evt;
    end
  end

  // Colour index steps on short presses, enable toggles on long presses
  always_ff @(posedge clk) begin
    if (rst) begin
      colour_idx <= COLOUR_RESET;
      leds_on    <= 1'b1;
    end else begin
      if (short_pulse)
        colour_idx <= (colour_idx == COLOUR_LAST) ? 3'd0 : colour_idx + 3'd1;
      if (long_pulse)
        leds_on <= ~leds_on;
    end
  end

  assign lit_rgb = colour_rgb(colour_idx) & {3{leds_on}};

  // Registered active-low LED pins; reset shows the reset colour (green)
  always_ff @(posedge clk) begin
    if (rst) begin
      led_red   <= 1'b1;
      led_green <= 1'b0;
      led_blue  <= 1'b1;
    end else begin
      led_red   <= ~lit_rgb[2];
      led_green <= ~lit_rgb[1];
      led_blue  <= ~lit_rgb[0];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_button_rgb_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_rgb_reader
//  Description : Self-checking bench for button_rgb_reader (DEBOUNCE_CYCLES=4,
//                LONG_CYCLES=20). Expected pulses are queued with their cycle
//                when a press is driven and matched as the DUT emits them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_rgb_reader;

  localparam int D = 4;
  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic btn_pressed, short_pulse, long_pulse;
  logic led_red, led_green, led_blue;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit is_long;
    int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  // Reference colour table {R,G,B} and bench model of index / enable
  logic [2:0] tbl [0:6] = '{3'b100, 3'b010, 3'b001, 3'b110, 3'b011, 3'b101, 3'b111};
  int m_idx = 1;
  bit m_on  = 1'b1;

  button_rgb_reader #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_pressed (btn_pressed),
    .short_pulse (short_pulse),
    .long_pulse  (long_pulse),
    .led_red     (led_red),
    .led_green   (led_green),
    .led_blue    (led_blue)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every pulse seen must match the head of the expected queue
  always @(negedge clk) begin
    if (short_pulse === 1'b1 || long_pulse === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: got short=%0b long=%0b at cycle %0d, required no pulse",
                 short_pulse, long_pulse, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if ({short_pulse, long_pulse} !== {~mon_e.is_long, mon_e.is_long} || cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL pulse_match: got short=%0b long=%0b at cycle %0d, required short=%0b long=%0b at cycle %0d",
                   short_pulse, long_pulse, cyc, ~mon_e.is_long, mon_e.is_long, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] exp_leds();
    logic [2:0] t;
    t = tbl[m_idx];
    return ~(t & {3{m_on}});
  endfunction

  // One press held for 'hold' cycles; the pulse and LED change are predicted
  // from the sample edge k where the low level is first seen.
  task automatic do_press(input int hold, input bit already_low, input string name);
    int n, k, r, chg, end_cyc;
    bit lng;
    logic [2:0] old_l, new_l;
    lng = (hold > L);
    n = cyc;
    k = n + 1;
    r = n + hold + 1;
    if (!already_low) btn_n = 1'b0;
    old_l = exp_leds();
    if (lng) begin
      exp_q.push_back('{1'b1, k + D + L + 2});
      chg = k + D + L + 4;
      m_on = ~m_on;
    end else begin
      exp_q.push_back('{1'b0, r + D + 2});
      chg = r + D + 4;
      m_idx = (m_idx == 6) ? 0 : m_idx + 1;
    end
    new_l = exp_leds();
    end_cyc = ((chg > r + D + 4) ? chg : r + D + 4) + 2;
    while (cyc < end_cyc) begin
      tick();
      if (cyc == n + hold) btn_n = 1'b1;
      if (cyc == k + D) begin
        checks++;
        if (btn_pressed !== 1'b0) begin
          errors++;
          $display("FAIL %s_db_early: btn_pressed=%b at cycle %0d, required 0", name, btn_pressed, cyc);
        end
      end
      if (cyc == k + D + 1) begin
        checks++;
        if (btn_pressed !== 1'b1) begin
          errors++;
          $display("FAIL %s_db_rise: btn_pressed=%b at cycle %0d, required 1", name, btn_pressed, cyc);
        end
      end
      if (cyc == r + D + 1) begin
        checks++;
        if (btn_pressed !== 1'b0) begin
          errors++;
          $display("FAIL %s_db_fall: btn_pressed=%b at cycle %0d, required 0", name, btn_pressed, cyc);
        end
      end
      if (cyc == chg - 1) begin
        checks++;
        if ({led_red, led_green, led_blue} !== old_l) begin
          errors++;
          $display("FAIL %s_led_hold: leds=%b at cycle %0d, required %b", name,
                   {led_red, led_green, led_blue}, cyc, old_l);
        end
      end
      if (cyc == chg) begin
        checks++;
        if ({led_red, led_green, led_blue} !== new_l) begin
          errors++;
          $display("FAIL %s_led_change: leds=%b at cycle %0d, required %b", name,
                   {led_red, led_green, led_blue}, cyc, new_l);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pulse_missing: %0d pulse(s) outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn_n = 1'b1;
    repeat (3) tick();
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b101) begin
      errors++;
      $display("FAIL reset_leds: leds=%b, required 101", {led_red, led_green, led_blue});
    end
    checks++;
    if ({btn_pressed, short_pulse, long_pulse} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: pressed/short/long=%b, required 000",
               {btn_pressed, short_pulse, long_pulse});
    end
    rst = 1'b0;
    m_idx = 1;
    m_on = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) btn_n = ~btn_n;
      tick();
      checks++;
      if (btn_pressed !== 1'b0) begin
        errors++;
        $display("FAIL bounce_db: btn_pressed=%b at step %0d, required 0", btn_pressed, i);
      end
    end
    btn_n = 1'b1;
    repeat (8) tick();
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b101) begin
      errors++;
      $display("FAIL bounce_leds: leds=%b, required 101", {led_red, led_green, led_blue});
    end
  endtask

  task automatic test_short();
    do_press(10, 1'b0, "short_first");
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b110) begin
      errors++;
      $display("FAIL short_blue: leds=%b, required 110", {led_red, led_green, led_blue});
    end
    for (int i = 0; i < 6; i++) begin
      do_press(10, 1'b0, "short_seq");
      repeat (2) tick();
    end
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b101) begin
      errors++;
      $display("FAIL short_wrap: leds=%b, required 101 (green)", {led_red, led_green, led_blue});
    end
  endtask

  task automatic test_long();
    do_press(40, 1'b0, "long_off");
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b111) begin
      errors++;
      $display("FAIL long_off: leds=%b, required 111", {led_red, led_green, led_blue});
    end
    do_press(40, 1'b0, "long_on");
    checks++;
    if ({led_red, led_green, led_blue} !== 3'b101) begin
      errors++;
      $display("FAIL long_restore: leds=%b, required 101", {led_red, led_green, led_blue});
    end
  endtask

  task automatic test_tie();
    do_press(L, 1'b0, "tie");
    do_press(L + 1, 1'b0, "just_long_off");
    do_press(L + 1, 1'b0, "just_long_on");
  endtask

  task automatic test_reset_mid_hold();
    int n;
    n = cyc;
    btn_n = 1'b0;
    while (cyc < n + 1 + D + 5) tick();
    checks++;
    if (btn_pressed !== 1'b1) begin
      errors++;
      $display("FAIL midhold_pre: btn_pressed=%b, required 1", btn_pressed);
    end
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if ({led_red, led_green, led_blue, btn_pressed, short_pulse, long_pulse} !== 6'b101000) begin
      errors++;
      $display("FAIL midhold_reset: leds/pressed/short/long=%b, required 101000",
               {led_red, led_green, led_blue, btn_pressed, short_pulse, long_pulse});
    end
    rst = 1'b0;
    m_idx = 1;
    m_on = 1'b1;
    exp_q.delete();
    do_press(10, 1'b1, "midhold_post");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_short();
    test_long();
    test_tie();
    test_reset_mid_hold();
    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
